// File: rtl/key_debounce.sv
// Push-button debouncer timed by the rising edges of the 10 ms divider output.
// Optional auto-repeat is built when KEY_DEBOUNCE_AUTO_REPEAT_EN is defined.
module key_debounce #(
  parameter int N_SAMPLES    = 4,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic long_press,
  output logic key_repeat
);

  localparam logic [7:0]  N_LAST   = 8'(N_SAMPLES);
  localparam logic [15:0] LONG_LIM = 16'(LONG_TICKS);

  if (N_SAMPLES < 2 || N_SAMPLES > 255 || LONG_TICKS < 1 || LONG_TICKS > 65535 ||
      REPEAT_TICKS < 1 || REPEAT_TICKS > 65535) begin : g_bad_params
    $error("key_debounce: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  scnt_q, scnt_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic        key_meta, key_sync, key_s;
  logic        tick_prev, strobe;
  logic [7:0]  scnt_inc;
  logic [15:0] hcnt_inc;
  logic        hold_done;
  logic        level_d, press_d, release_d, long_d, repeat_d;

  // Synchronizer rests at the unpressed pin level; tick_prev follows tick_in
  // even in reset so releasing reset during a high tick cannot fake an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta  <= ACTIVE_LOW;
      key_sync  <= ACTIVE_LOW;
      tick_prev <= tick_in;
    end else begin
      key_meta  <= key_in;
      key_sync  <= key_meta;
      tick_prev <= tick_in;
    end
  end

  assign key_s     = key_sync ^ ACTIVE_LOW;
  assign strobe    = tick_in & ~tick_prev;
  assign scnt_inc  = scnt_q + 8'd1;
  assign hcnt_inc  = hcnt_q + 16'd1;
  assign hold_done = (hcnt_q == LONG_LIM);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      scnt_q  <= 8'd0;
      hcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Next-state logic; nothing moves except on a strobe
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    hcnt_d  = hcnt_q;
    if (strobe) begin
      case (state_q)
        IDLE: begin
          if (key_s) begin
            state_d = PRESS_WAIT;
            scnt_d  = 8'd1;
          end
        end
        PRESS_WAIT: begin
          if (!key_s) begin
            state_d = IDLE;
            scnt_d  = 8'd0;
          end else if (scnt_inc == N_LAST) begin
            state_d = HELD;
            scnt_d  = 8'd0;
            hcnt_d  = 16'd0;
          end else begin
            scnt_d  = scnt_inc;
          end
        end
        HELD: begin
          if (key_s) begin
            if (!hold_done) hcnt_d = hcnt_inc;
          end else begin
            state_d = RELEASE_WAIT;
            scnt_d  = 8'd1;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to pressed keeps hcnt so long_press cannot re-arm
          if (key_s) begin
            state_d = HELD;
            scnt_d  = 8'd0;
          end else if (scnt_inc == N_LAST) begin
            state_d = IDLE;
            scnt_d  = 8'd0;
            hcnt_d  = 16'd0;
          end else begin
            scnt_d  = scnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          scnt_d  = 8'd0;
          hcnt_d  = 16'd0;
        end
      endcase
    end
  end

  // Output decode: next values of the registered outputs
  always_comb begin
    level_d   = key_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    if (strobe) begin
      case (state_q)
        PRESS_WAIT: begin
          if (key_s && scnt_inc == N_LAST) begin
            press_d = 1'b1;
            level_d = 1'b1;
          end
        end
        HELD: begin
          if (key_s && !hold_done && hcnt_inc == LONG_LIM) long_d = 1'b1;
        end
        RELEASE_WAIT: begin
          if (!key_s && scnt_inc == N_LAST) begin
            release_d = 1'b1;
            level_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
  localparam logic [15:0] REP_LIM = 16'(REPEAT_TICKS);

  logic [15:0] rcnt_q, rcnt_d;
  logic [15:0] rcnt_inc;

  assign rcnt_inc = rcnt_q + 16'd1;

  // rcnt only runs once hcnt has saturated, i.e. after long_press fired
  always_comb begin
    rcnt_d   = rcnt_q;
    repeat_d = 1'b0;
    if (strobe) begin
      if (state_q == HELD && key_s && hold_done) begin
        if (rcnt_inc == REP_LIM) begin
          rcnt_d   = 16'd0;
          repeat_d = 1'b1;
        end else begin
          rcnt_d   = rcnt_inc;
        end
      end else if (state_d == IDLE) begin
        rcnt_d = 16'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rcnt_q <= 16'd0;
    else     rcnt_q <= rcnt_d;
  end
`else
  assign repeat_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      long_press  <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
      long_press  <= long_d;
      key_repeat  <= repeat_d;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: N_SAMPLES=4, LONG_TICKS=10, REPEAT_TICKS=3,
// active-low key, tick_in toggling every 5 clk (one strobe per 10 clk).
module tb_key_debounce;

  logic clk, rst, tick_in, key_in;
  logic key_level, key_press, key_release, long_press, key_repeat;

  int total = 0;
  int bad   = 0;

  int strobe_n = 0;
  int div      = 0;

  int press_cnt = 0, release_cnt = 0, long_cnt = 0, rep_cnt = 0, overlap = 0;
  int press_at = -1, release_at = -1, long_at = -1, rep_first_at = -1, rep_last_at = -1;
  logic lvl_before_press = 1'b0, lvl_at_press = 1'b0, prev_level = 1'b0;
  int press_snap = 0, release_snap = 0, long_snap = 0, rep_snap = 0;
  int base;

  key_debounce #(
    .N_SAMPLES(4),
    .LONG_TICKS(10),
    .REPEAT_TICKS(3),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick_in(tick_in),
    .key_in(key_in),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .long_press(long_press),
    .key_repeat(key_repeat)
  );

  // Clock and divider stand-in: tick_in changes on negedge, strobe_n counts rises
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick_in = 1'b0;
    forever begin
      @(negedge clk);
      if (div == 4) begin
        div = 0;
        tick_in = ~tick_in;
        if (tick_in) strobe_n++;
      end else begin
        div++;
      end
    end
  end

  // Pulse monitor: records count and deciding strobe index of each pulse type
  always @(negedge clk) begin
    if (key_press === 1'b1) begin
      press_cnt++;
      press_at = strobe_n;
      lvl_before_press = prev_level;
      lvl_at_press = key_level;
    end
    if (key_release === 1'b1) begin
      release_cnt++;
      release_at = strobe_n;
    end
    if (long_press === 1'b1) begin
      long_cnt++;
      long_at = strobe_n;
    end
    if (key_repeat === 1'b1) begin
      if (rep_cnt == rep_snap) rep_first_at = strobe_n;
      rep_cnt++;
      rep_last_at = strobe_n;
    end
    if (key_press === 1'b1 && key_release === 1'b1) overlap++;
    prev_level = key_level;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(negedge clk);
    #1;
  endtask

  // Waits for n strobes, then 2 clk so key changes settle before the next strobe
  task automatic wait_strobes(input int n);
    int target;
    target = strobe_n + n;
    for (int i = 0; i < n * 12 + 20 && strobe_n < target; i++) step_clk();
    if (strobe_n < target) begin
      bad++;
      $display("FAIL strobe_wait: observed=%0d expected=%0d", strobe_n, target);
    end
    step_clk();
    step_clk();
  endtask

  task automatic snap();
    press_snap   = press_cnt;
    release_snap = release_cnt;
    long_snap    = long_cnt;
    rep_snap     = rep_cnt;
  endtask

  initial begin
    rst    = 1'b1;
    key_in = 1'b1;
    repeat (3) step_clk();
    check("rst_level",   key_level,   0);
    check("rst_press",   key_press,   0);
    check("rst_release", key_release, 0);
    check("rst_long",    long_press,  0);
    check("rst_repeat",  key_repeat,  0);
    rst = 1'b0;

    // Glitch of 3 clk between strobes must not be seen
    wait_strobes(1);
    snap();
    key_in = 1'b0;
    repeat (3) step_clk();
    key_in = 1'b1;
    wait_strobes(5);
    check("glitch_press", press_cnt - press_snap, 0);
    check("glitch_level", key_level, 0);

    // Clean press held for 8 strobes
    snap();
    base = strobe_n;
    key_in = 1'b0;
    wait_strobes(8);
    check("clean_press_cnt",  press_cnt - press_snap, 1);
    check("clean_press_at",   press_at, base + 4);
    check("clean_lvl_before", lvl_before_press, 0);
    check("clean_lvl_at",     lvl_at_press, 1);
    check("clean_level",      key_level, 1);
    check("clean_release",    release_cnt - release_snap, 0);
    check("clean_long",       long_cnt - long_snap, 0);
    check("clean_repeat",     rep_cnt - rep_snap, 0);

    // Release with bounce: high 2, low 1, high 4
    snap();
    base = strobe_n;
    key_in = 1'b1;
    wait_strobes(2);
    key_in = 1'b0;
    wait_strobes(1);
    check("relb_mid_level",   key_level, 1);
    check("relb_mid_release", release_cnt - release_snap, 0);
    key_in = 1'b1;
    wait_strobes(4);
    check("relb_release_cnt", release_cnt - release_snap, 1);
    check("relb_release_at",  release_at, base + 7);
    check("relb_level",       key_level, 0);
    check("relb_press",       press_cnt - press_snap, 0);
    check("relb_long",        long_cnt - long_snap, 0);

    // Press with bounce (low 2, high 1, low 4), then keep holding for long press
    snap();
    base = strobe_n;
    key_in = 1'b0;
    wait_strobes(2);
    key_in = 1'b1;
    wait_strobes(1);
    key_in = 1'b0;
    wait_strobes(4);
    check("pb_press_cnt", press_cnt - press_snap, 1);
    check("pb_press_at",  press_at, base + 7);
    check("pb_release",   release_cnt - release_snap, 0);
    wait_strobes(20);
    check("long_cnt", long_cnt - long_snap, 1);
    check("long_at",  long_at, base + 17);
    check("long_level", key_level, 1);
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
    check("rep_cnt",      rep_cnt - rep_snap, 3);
    check("rep_first_at", rep_first_at, base + 20);
    check("rep_last_at",  rep_last_at, base + 26);
`else
    check("rep_cnt", rep_cnt - rep_snap, 0);
`endif

    // One-sample release bounce after long_press must not fire it again
    snap();
    key_in = 1'b1;
    wait_strobes(1);
    key_in = 1'b0;
    wait_strobes(10);
    check("bounce_long",    long_cnt - long_snap, 0);
    check("bounce_release", release_cnt - release_snap, 0);
    check("bounce_level",   key_level, 1);

    // Reset for one clk while HELD, released with tick_in still high
    snap();
    rst = 1'b1;
    step_clk();
    check("mrst_level",   key_level,   0);
    check("mrst_press",   key_press,   0);
    check("mrst_release", key_release, 0);
    check("mrst_long",    long_press,  0);
    check("mrst_repeat",  key_repeat,  0);
    rst = 1'b0;
    base = strobe_n;
    wait_strobes(6);
    check("mrst_no_release", release_cnt - release_snap, 0);
    check("mrst_press_cnt",  press_cnt - press_snap, 1);
    check("mrst_press_at",   press_at, base + 4);
    check("mrst_level_after", key_level, 1);

    // Clean release
    snap();
    base = strobe_n;
    key_in = 1'b1;
    wait_strobes(5);
    check("final_release_cnt", release_cnt - release_snap, 1);
    check("final_release_at",  release_at, base + 4);
    check("final_level",       key_level, 0);
    check("final_press",       press_cnt - press_snap, 0);

    check("press_release_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Debounces one raw push-button input, using the slow sampling clock produced by the 10 ms divider as its sample timebase.
- Converts the divider's toggling square-wave output into a single-cycle sample strobe in the main clk domain.
- Emits a clean key level plus one-clk pulses for press, release, long-press and auto-repeat.
- Sits between board key pins and the control FSMs of the final-test design.

Parameters:
N_SAMPLES, 4, consecutive equal samples required to accept a level change (legal range 2..255)
LONG_TICKS, 100, samples held before long_press fires (100 = ~1 s at 10 ms; legal range 1..65535)
REPEAT_TICKS, 20, samples between key_repeat pulses after long_press (legal range 1..65535)
ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed

Ports:
clk  input  1  system clock; the same clock that drives the divider
rst  input  1  synchronous, active-high reset
tick_in  input  1  divider's toggling output (level, not a pulse); clk-synchronous
key_in  input  1  raw asynchronous button pin
key_level  output  1  debounced state, 1 = pressed
key_press  output  1  one-clk pulse on accepted press
key_release  output  1  one-clk pulse on accepted release
long_press  output  1  one-clk pulse, at most once per press
key_repeat  output  1  one-clk auto-repeat pulse (0 when feature is compiled out)

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - State = IDLE; sample counter and hold counter = 0.
  - All outputs = 0.
  - Synchronizer flops load the unpressed raw level: 1 if ACTIVE_LOW, else 0.
  - tick_prev loads tick_in, so no spurious strobe occurs after reset release.
  - Reset asserted mid-press aborts silently: no key_release is generated.
- Sampling:
  - Two-flop synchronizer on key_in, then XOR with ACTIVE_LOW gives key_s (1 = pressed).
  - strobe = tick_in & ~tick_prev (rising edge only); tick_prev <= tick_in every clk.
  - All state changes below happen only on clk cycles where strobe=1.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE:
    - key_s=1: go to PRESS_WAIT, scnt=1.
  - PRESS_WAIT:
    - key_s=0: go to IDLE, scnt=0.
    - key_s=1: scnt+1; when scnt+1 == N_SAMPLES, go to HELD, key_level<=1, pulse key_press, hcnt=0, scnt=0.
  - HELD:
    - key_s=1: hcnt increments, saturating at LONG_TICKS.
    - The strobe on which hcnt becomes LONG_TICKS pulses long_press.
    - key_s=0: go to RELEASE_WAIT, scnt=1.
  - RELEASE_WAIT:
    - key_s=1: return to HELD, scnt=0; hcnt is kept and does not advance on that sample.
    - key_s=0: scnt+1; when scnt+1 == N_SAMPLES, go to IDLE, key_level<=0, pulse key_release, hcnt=0.
- Timing:
  - All outputs are registered.
  - Pulses assert on the clk after the deciding strobe and last exactly one clk.
  - Latency from a stable key edge to a pulse: 2 clk (synchronizer) + (N_SAMPLES) strobes ± 1 strobe period + 1 clk.
- Boundary conditions:
  - long_press never fires twice per press, including across HELD/RELEASE_WAIT bounces.
  - key_press and key_release are never asserted in the same cycle.
  - A glitch shorter than one strobe period is invisible.
  - The counters never wrap.

Optional Feature:
KEY_DEBOUNCE_AUTO_REPEAT_EN
- Defined:
  - In HELD, a repeat counter rcnt starts after long_press.
  - rcnt counts strobes while key_s=1; at REPEAT_TICKS it pulses key_repeat and reloads to 0.
  - The first key_repeat fires REPEAT_TICKS strobes after long_press.
  - rcnt is cleared on entry to IDLE and on reset; it is frozen while in RELEASE_WAIT.
- Undefined:
  - key_repeat is tied to 0.
  - No rcnt logic is built; the port list is unchanged.

Test Plan:
(Bench params for all cases: N_SAMPLES=4, LONG_TICKS=10, REPEAT_TICKS=3, ACTIVE_LOW=1; tick_in toggles every 5 clk, giving a strobe every 10 clk.)
1. Clean press: key_in 1→0 and held for 8 strobes -> exactly one key_press, 1 clk after the 4th strobe that samples pressed; key_level=1 from the same clk; no other pulses.
2. Bounce: key_in low for 2 strobes, high 1 strobe, low 4 strobes -> a single key_press after the final 4 consecutive samples; no key_release.
3. Release with bounce: from HELD, key_in high 2 strobes, low 1, high 4 -> stays HELD through the bounce; one key_release after 4 consecutive high samples; key_level=0.
4. Long press: hold key_in low for 30 strobes -> key_press, then exactly one long_press 10 strobes after entering HELD; with the macro defined, key_repeat at +3, +6, +9 … strobes after long_press; without it, key_repeat stays 0.
5. Reset mid-press: assert rst for 1 clk while in HELD with key_in still low -> all outputs 0 the next clk; no key_release; a new key_press after 4 further pressed strobes.
6. Reset with tick_in=1: release rst while tick_in is high -> no strobe until the next 0→1 transition of tick_in (verified by the sample count to key_press).
